// File: rtl/mass_pipeline_pkg.sv
// Shared definitions for the mass update pipeline: engine state encoding and
// signed saturation limits for an arbitrary word width.
package mass_pipeline_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CALC  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Limits are returned at a fixed wide width; callers slice to their own width.
  localparam int LIMIT_W = 64;

  function automatic logic signed [LIMIT_W-1:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [LIMIT_W-1:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/verlet_sat.sv
// Combinational saturating Verlet step: x_next = sat(2*x_cur - x_prev + (accel >>> FORCE_SHIFT)).
module verlet_sat
  import mass_pipeline_pkg::*;
#(
  parameter int SIZE        = 27,
  parameter int FORCE_SHIFT = 4
) (
  input  logic signed [SIZE-1:0] x_cur,
  input  logic signed [SIZE-1:0] x_prev,
  input  logic signed [SIZE-1:0] accel,
  output logic signed [SIZE-1:0] x_next,
  output logic                   sat
);

  // Three guard bits cover 2*x - xp + f without wrap for any operand values.
  localparam int W = SIZE + 3;

  localparam logic signed [LIMIT_W-1:0] HI64 = sat_max(SIZE);
  localparam logic signed [LIMIT_W-1:0] LO64 = sat_min(SIZE);
  localparam logic signed [W-1:0]       HI   = HI64[W-1:0];
  localparam logic signed [W-1:0]       LO   = LO64[W-1:0];

  logic signed [W-1:0] x_e;
  logic signed [W-1:0] xp_e;
  logic signed [W-1:0] f_e;
  logic signed [W-1:0] f_sh;
  logic signed [W-1:0] sum;

  always_comb begin
    // NOTE: every output gets a default first, so no path can leave a latch behind.
    x_next = '0;
    sat    = 1'b0;

    x_e  = {{3{x_cur[SIZE-1]}}, x_cur};
    xp_e = {{3{x_prev[SIZE-1]}}, x_prev};
    f_e  = {{3{accel[SIZE-1]}}, accel};
    f_sh = f_e >>> FORCE_SHIFT;
    sum  = (x_e <<< 1) - xp_e + f_sh;

    if (sum > HI) begin
      x_next = HI[SIZE-1:0];
      sat    = 1'b1;
    end else if (sum < LO) begin
      x_next = LO[SIZE-1:0];
      sat    = 1'b1;
    end else begin
      x_next = sum[SIZE-1:0];
    end
  end

endmodule

// File: rtl/mass_update_engine.sv
// Frame engine: walks every mass, reads position/previous position from two
// 2-cycle-latency RAMs, applies a saturating Verlet step and writes both back.
module mass_update_engine
  import mass_pipeline_pkg::*;
#(
  parameter int SIZE        = 27,
  parameter int ADDR_WIDTH  = 5,
  parameter int NUM_MASSES  = 32,
  parameter int FORCE_SHIFT = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         force_valid,
  output logic                         force_ready,
  input  logic signed [SIZE-1:0]       force_data,
  output logic        [ADDR_WIDTH-1:0] ram_addr,
  output logic                         ram_we,
  output logic signed [SIZE-1:0]       x_d,
  output logic signed [SIZE-1:0]       xp_d,
  input  logic signed [SIZE-1:0]       x_q,
  input  logic signed [SIZE-1:0]       xp_q,
  output logic                         out_valid,
  output logic        [ADDR_WIDTH-1:0] out_index,
  output logic signed [SIZE-1:0]       out_data,
  output logic                         busy,
  output logic                         done,
  output logic                         sat_flag
);

  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(NUM_MASSES - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   index;
  logic signed [SIZE-1:0]  force_q;
  logic signed [SIZE-1:0]  x_new;
  logic signed [SIZE-1:0]  x_old;
  logic signed [SIZE-1:0]  calc_x;
  logic                    calc_sat;
  logic                    last_mass;

  assign last_mass = (index == LAST_INDEX);

  verlet_sat #(
    .SIZE        (SIZE),
    .FORCE_SHIFT (FORCE_SHIFT)
  ) u_verlet (
    .x_cur  (x_q),
    .x_prev (xp_q),
    .accel  (force_q),
    .x_next (calc_x),
    .sat    (calc_sat)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_FETCH;
      ST_FETCH: if (force_valid) state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_CALC;
      ST_CALC:  state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = last_mass ? ST_DONE : ST_FETCH;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers; RAM read data is only trusted in CALC, two cycles after FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index    <= '0;
      force_q  <= '0;
      x_new    <= '0;
      x_old    <= '0;
      sat_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            index    <= '0;
            sat_flag <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (force_valid) force_q <= force_data;
        end
        ST_CALC: begin
          x_new <= calc_x;
          x_old <= x_q;
          if (calc_sat) sat_flag <= 1'b1;
        end
        ST_WRITE: begin
          if (!last_mass) index <= index + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    force_ready = 1'b0;
    ram_addr    = '0;
    ram_we      = 1'b0;
    x_d         = '0;
    xp_d        = '0;
    out_valid   = 1'b0;
    out_index   = '0;
    out_data    = '0;
    done        = 1'b0;
    busy        = (state != ST_IDLE);
    case (state)
      ST_FETCH: begin
        force_ready = 1'b1;
        ram_addr    = index;
      end
      ST_WAIT, ST_CALC: ram_addr = index;
      ST_WRITE: begin
        ram_addr  = index;
        ram_we    = 1'b1;
        x_d       = x_new;
        xp_d      = x_old;
        out_valid = 1'b1;
        out_index = index;
        out_data  = x_new;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mass_update_engine.sv
// Self-checking bench for mass_update_engine: behavioural 2-cycle RAMs, a
// reference Verlet model and a scoreboard of expected per-mass writes.
module tb_mass_update_engine;

  localparam int SIZE = 27;
  localparam int AW   = 5;
  localparam int N    = 4;
  localparam int FS   = 4;
  localparam longint SMAX = (longint'(1) <<< (SIZE - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (SIZE - 1));

  typedef struct {
    logic [AW-1:0]          idx;
    logic signed [SIZE-1:0] xn;
    logic signed [SIZE-1:0] xo;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic                   force_valid;
  logic                   force_ready;
  logic signed [SIZE-1:0] force_data;
  logic [AW-1:0]          ram_addr;
  logic                   ram_we;
  logic signed [SIZE-1:0] x_d, xp_d, x_q, xp_q;
  logic                   out_valid;
  logic [AW-1:0]          out_index;
  logic signed [SIZE-1:0] out_data;
  logic                   busy, done, sat_flag;

  logic signed [SIZE-1:0] x_mem  [0:(1<<AW)-1];
  logic signed [SIZE-1:0] xp_mem [0:(1<<AW)-1];
  logic signed [SIZE-1:0] x_s1, xp_s1;
  logic                   pre_en = 1'b0;
  logic [AW-1:0]          pre_addr = '0;
  logic signed [SIZE-1:0] pre_x = '0, pre_xp = '0;

  longint m_x  [N];
  longint m_xp [N];
  exp_t   sb [$];
  int     n_tests = 0;
  int     n_fail  = 0;

  always #5 clk = ~clk;

  mass_update_engine #(
    .SIZE(SIZE), .ADDR_WIDTH(AW), .NUM_MASSES(N), .FORCE_SHIFT(FS)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .force_valid(force_valid), .force_ready(force_ready), .force_data(force_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .x_d(x_d), .xp_d(xp_d),
    .x_q(x_q), .xp_q(xp_q),
    .out_valid(out_valid), .out_index(out_index), .out_data(out_data),
    .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  // Two independent RAMs sharing address/we; read data appears two cycles after the address.
  always @(posedge clk) begin
    x_s1  <= x_mem[ram_addr];
    xp_s1 <= xp_mem[ram_addr];
    x_q   <= x_s1;
    xp_q  <= xp_s1;
    if (ram_we) begin
      x_mem[ram_addr]  <= x_d;
      xp_mem[ram_addr] <= xp_d;
    end else if (pre_en) begin
      x_mem[pre_addr]  <= pre_x;
      xp_mem[pre_addr] <= pre_xp;
    end
  end

  function automatic longint model_next(input longint x, input longint xp, input longint f,
                                        output bit s);
    longint v;
    v = 2 * x - xp + (f >>> FS);
    s = 1'b0;
    if (v > SMAX) begin v = SMAX; s = 1'b1; end
    else if (v < SMIN) begin v = SMIN; s = 1'b1; end
    return v;
  endfunction

  task automatic preload(input int a, input longint x, input longint xp);
    @(negedge clk);
    pre_en   = 1'b1;
    pre_addr = AW'(a);
    pre_x    = SIZE'(x);
    pre_xp   = SIZE'(xp);
    @(negedge clk);
    pre_en   = 1'b0;
    m_x[a]   = x;
    m_xp[a]  = xp;
  endtask

  // Runs one frame; cycle 1 is the cycle start is high, so lat is the cycle done is seen in.
  task automatic run_frame(input longint f[N], input int stall_at, input int stall_len,
                           input bit extra_start, input bit exp_sat_req, output int lat);
    exp_t   e;
    bit     s;
    bit     exp_sat;
    longint xn;
    int     cyc, fidx, stall_left, n_out, n_done, done_cyc;
    exp_sat = 1'b0;
    for (int i = 0; i < N; i++) begin
      xn   = model_next(m_x[i], m_xp[i], f[i], s);
      e.idx = AW'(i);
      e.xn  = SIZE'(xn);
      e.xo  = SIZE'(m_x[i]);
      sb.push_back(e);
      exp_sat |= s;
      m_xp[i] = m_x[i];
      m_x[i]  = xn;
    end
    n_tests++;
    if (exp_sat !== exp_sat_req) begin
      n_fail++;
      $display("FAIL model_sat: model saturation %0b, scenario intends %0b", exp_sat, exp_sat_req);
    end

    @(negedge clk);
    start = 1'b1; force_valid = 1'b0;
    cyc = 1; fidx = 0; stall_left = stall_len; n_out = 0; n_done = 0; done_cyc = -1;
    while (cyc < 200 && (done_cyc < 0 || cyc < done_cyc + 3)) begin
      @(negedge clk);
      cyc++;
      start = extra_start && (cyc == 6 || cyc == 13);
      if (cyc == 2) begin
        n_tests++;
        if (busy !== 1'b1 || sat_flag !== 1'b0) begin
          n_fail++;
          $display("FAIL frame_begin: busy=%b sat_flag=%b, want busy=1 sat_flag=0", busy, sat_flag);
        end
      end
      n_tests++;
      if (ram_we !== out_valid) begin
        n_fail++;
        $display("FAIL we_vs_valid cyc %0d: ram_we=%b out_valid=%b", cyc, ram_we, out_valid);
      end
      if (out_valid === 1'b1) begin
        n_out++;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL extra_output cyc %0d: index %0d data %0d with empty scoreboard",
                   cyc, out_index, out_data);
        end else begin
          e = sb.pop_front();
          if (out_index !== e.idx || out_data !== e.xn || ram_addr !== e.idx ||
              x_d !== e.xn || xp_d !== e.xo) begin
            n_fail++;
            $display("FAIL mass_write cyc %0d: idx=%0d addr=%0d data=%0d x_d=%0d xp_d=%0d, want idx=addr=%0d data=x_d=%0d xp_d=%0d",
                     cyc, out_index, ram_addr, out_data, x_d, xp_d, e.idx, e.xn, e.xo);
          end
        end
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          n_tests++;
          if (sat_flag !== exp_sat) begin
            n_fail++;
            $display("FAIL sat_flag: got %b want %b", sat_flag, exp_sat);
          end
        end
      end
      if (force_ready === 1'b1 && fidx < N) begin
        if (fidx == stall_at && stall_left > 0) begin
          force_valid = 1'b0;
          stall_left--;
        end else begin
          force_valid = 1'b1;
          force_data  = SIZE'(f[fidx]);
          fidx++;
        end
      end else begin
        force_valid = 1'b0;
      end
    end
    start = 1'b0; force_valid = 1'b0;
    n_tests++;
    if (done_cyc < 0 || n_out != N || n_done != 1 || sb.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_end: done_cyc=%0d outs=%0d dones=%0d left=%0d busy=%b, want outs=%0d dones=1 left=0 busy=0",
               done_cyc, n_out, n_done, sb.size(), busy, N);
    end
    sb.delete();
    lat = done_cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; force_valid = 1'b0; force_data = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({ram_we, busy, done, sat_flag, force_ready, out_valid, ram_addr, out_index,
         out_data, x_d, xp_d} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: we=%b busy=%b done=%b sat=%b rdy=%b ov=%b addr=%0d, want all 0",
               ram_we, busy, done, sat_flag, force_ready, out_valid, ram_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    for (int i = 0; i < N; i++) preload(i, 0, 0);
    run_frame('{16, 32, -16, 0}, -1, 0, 1'b0, 1'b0, lat);
    n_tests++;
    if (lat != 4 * N + 2) begin
      n_fail++;
      $display("FAIL basic_latency: done at cycle %0d want %0d", lat, 4 * N + 2);
    end
    n_tests++;
    if (x_mem[0] !== 27'sd1 || x_mem[1] !== 27'sd2 || x_mem[2] !== -27'sd1 || x_mem[3] !== 27'sd0) begin
      n_fail++;
      $display("FAIL basic_ram: x=%0d,%0d,%0d,%0d want 1,2,-1,0", x_mem[0], x_mem[1], x_mem[2], x_mem[3]);
    end
  endtask

  task automatic test_verlet();
    int lat;
    preload(0, 100, 90);
    preload(1, -500, -480);
    preload(2, 7, 7);
    preload(3, 0, 0);
    run_frame('{0, 160, -33, 5}, -1, 0, 1'b0, 1'b0, lat);
    n_tests++;
    if (x_mem[0] !== 27'sd110 || xp_mem[0] !== 27'sd100) begin
      n_fail++;
      $display("FAIL verlet_ram: x=%0d xp=%0d want 110 100", x_mem[0], xp_mem[0]);
    end
  endtask

  task automatic test_saturation();
    int lat;
    preload(0, SMAX, 0);
    preload(1, SMIN, 0);
    preload(2, longint'(1) <<< 25, -(longint'(1) <<< 25));
    preload(3, 1000, 0);
    run_frame('{0, 0, 0, -1}, -1, 0, 1'b0, 1'b1, lat);
    // Masses 0 and 1 now sit exactly at the limits with zero velocity: no saturation next frame.
    preload(2, 3, 1);
    preload(3, 0, 0);
    run_frame('{0, 0, 0, 0}, -1, 0, 1'b0, 1'b0, lat);
  endtask

  task automatic test_stall();
    int     lat;
    longint f[N];
    for (int i = 0; i < N; i++) begin
      preload(i, longint'($urandom_range(0, 20000)) - 10000, longint'($urandom_range(0, 20000)) - 10000);
      f[i] = longint'($urandom_range(0, 2000000)) - 1000000;
    end
    run_frame(f, 2, 5, 1'b0, 1'b0, lat);
    n_tests++;
    if (lat != 4 * N + 2 + 5) begin
      n_fail++;
      $display("FAIL stall_latency: done at cycle %0d want %0d", lat, 4 * N + 7);
    end
  endtask

  task automatic test_back_to_back_start();
    int lat;
    run_frame('{-48, 64, 17, -1}, -1, 0, 1'b1, 1'b0, lat);
    n_tests++;
    if (lat != 4 * N + 2) begin
      n_fail++;
      $display("FAIL busy_start_latency: done at cycle %0d want %0d", lat, 4 * N + 2);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit                     s;
    bit                     seen;
    longint                 xn0;
    int                     lat;
    logic signed [SIZE-1:0] exp0;
    preload(0, 10, 4);
    preload(1, 20, 25);
    preload(2, 0, 0);
    preload(3, 0, 0);
    xn0  = model_next(10, 4, 48, s);
    exp0 = SIZE'(xn0);
    @(negedge clk);
    start = 1'b1; force_valid = 1'b1; force_data = 27'sd48;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen || out_index !== '0 || out_data !== exp0) begin
      n_fail++;
      $display("FAIL abort_mass0: seen=%b idx=%0d data=%0d want seen=1 idx=0 data=%0d",
               seen, out_index, out_data, exp0);
    end
    force_data = 27'sd64;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if ({ram_we, busy, done, sat_flag, force_ready, out_valid, ram_addr, out_index,
         out_data, x_d, xp_d} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: we=%b busy=%b done=%b rdy=%b ov=%b addr=%0d, want all 0",
               ram_we, busy, done, force_ready, out_valid, ram_addr);
    end
    m_xp[0] = 10;
    m_x[0]  = xn0;
    force_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (x_mem[1] !== 27'sd20 || xp_mem[1] !== 27'sd25 || x_mem[0] !== exp0) begin
      n_fail++;
      $display("FAIL abort_ram: m1 x=%0d xp=%0d m0 x=%0d, want 20 25 %0d", x_mem[1], xp_mem[1], x_mem[0], exp0);
    end
    reset = 1'b0;
    run_frame('{32, 0, -16, 64}, -1, 0, 1'b0, 1'b0, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_verlet();
    test_saturation();
    test_stall();
    test_back_to_back_start();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
